deadlock_idx0_monitor: RTL and testbench
========================================

Name: deadlock_idx0_monitor

Overview:
- Deadlock detector for one kernel hierarchy level (index 0) in the co-simulation monitor tree.
- Watches per-channel AXI-Stream "blocked" flags and per-sub-instance idle/blocked flags.
- Asserts `block` once the kernel has been stalled on a stream for THRESHOLD consecutive cycles with no enabled sub-instance making progress.
- Sits under the kernel monitor top; its `block` output feeds the deadlock trigger logic.

Parameters:
- NUM_AXIS, 2, number of AXI-Stream block flags (width of `axis_block_sigs`).
- NUM_INST, 1, number of sub-instances (width of `inst_idle_sigs` / `inst_block_sigs`).
- INST_MASK, {NUM_INST{1'b0}}, bit i=1 means instance i participates in the stall check; a masked-off instance is treated as stalled.
- THRESHOLD, 4, consecutive stall cycles required before `block` asserts (legal range 1..255).

Ports:
- clock, input, 1, monitor clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- axis_block_sigs, input, NUM_AXIS, bit j=1: stream j is blocked (TDATA_blk_n low).
- inst_idle_sigs, input, NUM_INST, bit i=1: sub-instance i is idle.
- inst_block_sigs, input, NUM_INST, bit i=1: sub-instance i is itself blocked.
- block, output, 1, registered deadlock indication.

Behaviour:
- Input stage: all three input vectors are registered once (axis_q, idle_q, iblk_q), giving 1 cycle of input latency. The registers clear to 0 on reset.
- axis_any = |axis_q.
- inst_stalled[i] = ~INST_MASK[i] | idle_q[i] | iblk_q[i].
- inst_all = &inst_stalled.
- stall = axis_any & inst_all.
- FSM states: IDLE, WATCH, BLOCKED. State is encoded in a 2-bit register; the counter cnt is 8 bits.
- Reset (reset=0, async): state=IDLE, cnt=0, block=0, input registers=0. Reset mid-operation clears everything immediately, including a BLOCKED condition.
- IDLE: if stall=1, cnt<=1. If additionally THRESHOLD==1, go to BLOCKED; otherwise go to WATCH. If stall=0, stay in IDLE with cnt=0.
- WATCH: if stall=0, go to IDLE and set cnt=0. If stall=1 and cnt+1==THRESHOLD, go to BLOCKED. Otherwise increment cnt.
- BLOCKED: block=1. If stall=0, go to IDLE next cycle, set cnt=0 and block=0, so block deasserts one cycle after stall drops. cnt holds at THRESHOLD and never wraps.
- block is a register: 1 exactly while state==BLOCKED.
- Latency: with stall held continuously from input edge E, block rises at edge E+THRESHOLD+1 (1 input register + THRESHOLD counting edges).
- A single-cycle drop of stall anywhere before BLOCKED restarts the count from 0.
- Which stream is blocked may change cycle to cycle without resetting the count, provided axis_any stays 1.
- Unknown/X on an input is not filtered: the inputs are assumed 2-state in simulation.
- Outputs have no combinational path from any input.

Decomposition:
- Shared package `deadlock_monitor_pkg`:
  - state enum `dl_state_t` {IDLE, WATCH, BLOCKED}
  - constant CNT_W=8
  - function `f_stall(axis, idle, iblk, mask)` reused by the other idx monitors.
- One natural sub-module: `deadlock_stall_counter`, holding the saturating consecutive-cycle counter with clear, compare-to-threshold and hit outputs. FSM and input registers stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles with axis_block_sigs=2'b11 -> block=0 throughout; state IDLE after release.
- Default masks (NUM_AXIS=2, INST_MASK=0, THRESHOLD=4), axis_block_sigs=2'b01 held from edge 10 -> block=0 at edges 10..14, block=1 from edge 15. Set axis_block_sigs=2'b00 -> block=0 one cycle after the registered input drops.
- Glitch: axis_block_sigs=2'b10 for 3 cycles, 2'b00 for 1 cycle, then 2'b10 held -> block rises only 5 edges after the re-assertion (count restarted).
- Instance veto: INST_MASK=1'b1, axis_block_sigs=2'b11 held, idle=0, inst_block=0 -> block stays 0 for 20 cycles. Raising inst_idle_sigs=1 -> block=1 after THRESHOLD+1 edges. Replacing idle with inst_block_sigs=1 keeps block=1.
- Async reset in BLOCKED: block=1, drive reset=0 mid-cycle -> block=0 before the next clock edge; after release with stall still 1, block re-asserts 5 edges later.
- THRESHOLD=1: single-cycle axis_block_sigs=2'b01 pulse -> block=1 for exactly one cycle, two edges after the pulse.

Source files
------------

// File: rtl/deadlock_monitor_pkg.sv
// Shared types and stall rule for the per-index deadlock monitors.
// The stall rule is kept here so every idx monitor applies the same definition.
package deadlock_monitor_pkg;

  localparam int CNT_W = 8;
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    BLOCKED = 2'd2
  } dl_state_t;

  // Callers zero-extend narrower vectors: unused lanes have axis=0, so they add no
  // stream stall, and mask=0, so they count as stalled instances.
  function automatic logic f_stall(input logic [MAX_W-1:0] axis,
                                   input logic [MAX_W-1:0] idle,
                                   input logic [MAX_W-1:0] iblk,
                                   input logic [MAX_W-1:0] mask);
    return (|axis) & (&(~mask | idle | iblk));
  endfunction

endpackage

// File: rtl/deadlock_stall_counter.sv
// Saturating count of consecutive stall cycles; hit flags that this cycle completes THRESHOLD.
// Latency: hit is combinational from the count register. No backpressure.
// Clear wins over increment; the count holds at THRESHOLD rather than wrapping.
module deadlock_stall_counter
  import deadlock_monitor_pkg::*;
#(
  parameter int THRESHOLD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_p1;

  assign cnt_p1 = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign hit    = (cnt_p1 == {1'b0, LIMIT});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt_p1[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for kernel hierarchy level 0 (up to 64 streams / instances).
// Latency: block rises 1 + THRESHOLD edges after a sustained stall appears on the inputs.
// No backpressure; block drops one edge after the registered stall condition clears.
module deadlock_idx0_monitor
  import deadlock_monitor_pkg::*;
#(
  parameter int                  NUM_AXIS  = 2,
  parameter int                  NUM_INST  = 1,
  parameter logic [NUM_INST-1:0] INST_MASK = {NUM_INST{1'b0}},
  parameter int                  THRESHOLD = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                block
);

  logic [NUM_AXIS-1:0] axis_q;
  logic [NUM_INST-1:0] idle_q;
  logic [NUM_INST-1:0] iblk_q;
  logic                stall;
  logic                hit;
  dl_state_t           state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      axis_q <= '0;
      idle_q <= '0;
      iblk_q <= '0;
    end else begin
      axis_q <= axis_block_sigs;
      idle_q <= inst_idle_sigs;
      iblk_q <= inst_block_sigs;
    end
  end

  assign stall = f_stall(MAX_W'(axis_q), MAX_W'(idle_q), MAX_W'(iblk_q), MAX_W'(INST_MASK));

  deadlock_stall_counter #(
    .THRESHOLD(THRESHOLD)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (~stall),
    .inc  (stall),
    .hit  (hit)
  );

  // In IDLE the count is 0, so hit there means THRESHOLD==1 and we jump straight to BLOCKED.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      block <= 1'b0;
    end else begin
      case (state)
        IDLE, WATCH: begin
          if (!stall) begin
            state <= IDLE;
          end else if (hit) begin
            state <= BLOCKED;
            block <= 1'b1;
          end else begin
            state <= WATCH;
          end
        end
        BLOCKED: begin
          if (!stall) begin
            state <= IDLE;
            block <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          block <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Bench for deadlock_idx0_monitor: three parameterisations driven from shared inputs,
// checked against a stall-streak reference model plus directed constant expectations.
module tb_deadlock_idx0_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] axis  = 2'b00;
  logic [0:0] idle  = 1'b0;
  logic [0:0] iblk  = 1'b0;
  logic       blk_d, blk_m, blk_t;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  deadlock_idx0_monitor #(.NUM_AXIS(2), .NUM_INST(1), .INST_MASK(1'b0), .THRESHOLD(4)) dut_d (
    .clock(clock), .reset(reset), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .block(blk_d));

  deadlock_idx0_monitor #(.NUM_AXIS(2), .NUM_INST(1), .INST_MASK(1'b1), .THRESHOLD(4)) dut_m (
    .clock(clock), .reset(reset), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .block(blk_m));

  deadlock_idx0_monitor #(.NUM_AXIS(2), .NUM_INST(1), .INST_MASK(1'b0), .THRESHOLD(1)) dut_t (
    .clock(clock), .reset(reset), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .block(blk_t));

  // Reference: block at an edge is 1 when the inputs sampled at the preceding
  // THRESHOLD edges all described a stall; any non-stall sample zeroes the streak.
  int th_m[3]   = '{4, 4, 1};
  bit mask_m[3] = '{1'b0, 1'b1, 1'b0};
  int streak[3] = '{0, 0, 0};
  bit exp_blk[3] = '{1'b0, 1'b0, 1'b0};

  function automatic bit model_stall(int k);
    return (axis != 2'b00) && (!mask_m[k] || idle[0] || iblk[0]);
  endfunction

  always @(posedge clock or negedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        streak[k]  <= 0;
        exp_blk[k] <= 1'b0;
      end else begin
        exp_blk[k] <= (streak[k] >= th_m[k]);
        streak[k]  <= model_stall(k) ? streak[k] + 1 : 0;
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/d"}, blk_d, exp_blk[0]);
    chk({tag, "/m"}, blk_m, exp_blk[1]);
    chk({tag, "/t"}, blk_t, exp_blk[2]);
  endtask

  task automatic cyc(input int n, input string tag);
    repeat (n) begin
      @(negedge clock);
      chk_all(tag);
    end
  endtask

  initial begin
    // Reset held for three cycles with streams blocked
    #1 reset = 1'b0;
    axis = 2'b11;
    repeat (3) begin
      @(negedge clock);
      chk_all("reset");
      chk("reset_d0", blk_d, 1'b0);
      chk("reset_t0", blk_t, 1'b0);
    end
    reset = 1'b1;
    axis  = 2'b00;
    cyc(3, "idle");

    // Latency with default masks
    axis = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      chk_all("lat");
      chk("lat_d", blk_d, k >= 5);
      chk("lat_t", blk_t, k >= 2);
      chk("lat_m", blk_m, 1'b0);
    end
    axis = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk_all("drop");
      chk("drop_d", blk_d, k < 2);
    end

    // Glitch restarts the count
    axis = 2'b10;
    cyc(3, "glitch_a");
    axis = 2'b00;
    cyc(1, "glitch_b");
    axis = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      chk_all("glitch");
      chk("glitch_d", blk_d, k >= 5);
    end

    // Instance veto on the masked-in instance
    axis = 2'b11;
    idle = 1'b0;
    iblk = 1'b0;
    repeat (20) begin
      @(negedge clock);
      chk_all("veto");
      chk("veto_m", blk_m, 1'b0);
    end
    idle = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk_all("idle_on");
      chk("idle_on_m", blk_m, k >= 5);
    end
    idle = 1'b0;
    iblk = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk_all("iblk_hold");
      chk("iblk_hold_m", blk_m, 1'b1);
    end

    // Async reset while BLOCKED
    chk("pre_rst_d", blk_d, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_all("arst");
    chk("arst_d", blk_d, 1'b0);
    chk("arst_m", blk_m, 1'b0);
    @(negedge clock);
    chk_all("arst_hold");
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk_all("rearm");
      chk("rearm_d", blk_d, k >= 5);
    end

    // THRESHOLD=1 single-cycle pulse
    axis = 2'b00;
    iblk = 1'b0;
    cyc(3, "settle");
    axis = 2'b01;
    @(negedge clock);
    chk_all("pulse");
    chk("pulse_t1", blk_t, 1'b0);
    axis = 2'b00;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      chk_all("pulse");
      chk("pulse_t", blk_t, k == 2);
    end

    // Randomized phase: sticky inputs so long stalls occur, occasional async reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      chk_all("rand");
      reset = 1'b1;
      if ($urandom_range(0, 9) == 0) axis = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) iblk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        #1 chk_all("rand_arst");
      end
    end
    reset = 1'b1;
    cyc(2, "tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
